// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit buffering path.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } fifo_tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte buffer with wrap-bit pointers; reports occupancy and flags dropped pushes.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] head_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic                   overflow_q, overflow_d;
  logic                   wr_en;
  logic                   rd_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [ADDR_W-1:0]      rd_addr;

  assign wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];

  // Flags come straight from the registered pointers, so a same-cycle pop never rescues a push into a full buffer.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_addr == rd_addr) && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign overflow  = overflow_q;
  assign head_data = mem_q[rd_addr];

  always_comb begin
    wr_en      = push & ~full;
    rd_en      = pop & ~empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = push & full;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; only slots behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers producer bytes and feeds them one at a time to the UART transmitter handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_done
);

  fifo_tx_state_e         state_q, state_d;
  logic                   tx_start_q, tx_start_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   pop;
  logic [UART_DATA_W-1:0] head_data;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  // Launch pops the head into tx_data, which then holds until the next launch.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          state_d    = LAUNCH;
          tx_start_d = 1'b1;
          tx_data_d  = head_data;
          pop        = 1'b1;
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_done)      state_d = IDLE;
        else if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: queue-based reference model plus a simple serial transmitter model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned FRAME  = 160;

  logic             clk = 1'b0;
  logic             rst;
  logic             push;
  logic [7:0]       push_data;
  logic             full, empty, overflow, tx_start;
  logic [ADDR_W:0]  count;
  logic [7:0]       tx_data;
  logic             tx_busy, tx_done;

  logic             hold_busy;
  logic             xm_busy, xm_done;
  int unsigned      xm_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  assign tx_busy = xm_busy | hold_busy;
  assign tx_done = xm_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter: busy one cycle after tx_start, done pulse as busy drops FRAME cycles later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      xm_busy <= 1'b0;
      xm_done <= 1'b0;
      xm_cnt  <= 0;
    end else begin
      xm_done <= 1'b0;
      if (tx_start && !xm_busy) begin
        xm_busy <= 1'b1;
        xm_cnt  <= FRAME;
      end else if (xm_busy) begin
        if (xm_cnt == 1) begin
          xm_busy <= 1'b0;
          xm_done <= 1'b1;
        end
        xm_cnt <= xm_cnt - 1;
      end
    end
  end

  // Reference model: byte queue plus a "sender idle" flag.
  logic [7:0] mq[$];
  bit         m_idle;
  bit         m_start;
  logic [7:0] m_data;
  bit         m_ovf;
  int         m_sz;
  bit         m_launch;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_idle  = 1;
      m_start = 0;
      m_data  = 8'h00;
      m_ovf   = 0;
    end else begin
      m_sz     = mq.size();
      m_launch = m_idle && (m_sz != 0) && !tx_busy;
      m_ovf    = push && (m_sz == DEPTH);
      if (m_launch) m_data = mq.pop_front();
      if (push && (m_sz != DEPTH)) mq.push_back(push_data);
      if (m_launch) m_idle = 0;
      else if (!m_idle && !m_start && tx_done) m_idle = 1;
      m_start = m_launch;
    end
  end

  // Per-cycle compare and transmit log.
  logic [7:0] sent_q[$];
  int  n_starts  = 0;
  int  n_ovf     = 0;
  int  cyc       = 0;
  int  done_cyc  = 0;
  bit  done_seen = 0;
  bit  gap_en    = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_tx_start", 32'(tx_start), 32'(m_start));
      chk("cmp_tx_data",  32'(tx_data),  32'(m_data));
      chk("cmp_count",    32'(count),    32'(mq.size()));
      chk("cmp_empty",    32'(empty),    32'(mq.size() == 0));
      chk("cmp_full",     32'(full),     32'(mq.size() == DEPTH));
      chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
      if (tx_done) begin
        done_cyc  = cyc;
        done_seen = 1;
      end
      if (tx_start) begin
        sent_q.push_back(tx_data);
        n_starts++;
        if (gap_en && done_seen) chk("gap_done_to_start", 32'(cyc - done_cyc), 32'd2);
      end
      if (overflow) n_ovf++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] b);
    push      = 1'b1;
    push_data = b;
    @(posedge clk);
    #1;
    push      = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    bit ok = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      step(1);
      if (empty && !tx_busy && !tx_start && m_idle) ok = 1;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  int base;
  int sbase;
  bit got;

  initial begin
    rst       = 1'b1;
    push      = 1'b0;
    push_data = 8'h00;
    hold_busy = 1'b0;
    #3 rst = 1'b0;
    chk_en = 1;
    step(3);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'h00);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b1;
    step(2);

    // 1: single byte latency
    base = n_starts;
    do_push(8'hA5);
    chk("s1_count_after_push", 32'(count), 32'd1);
    chk("s1_no_start_yet", 32'(tx_start), 32'd0);
    step(1);
    chk("s1_tx_start", 32'(tx_start), 32'd1);
    chk("s1_tx_data", 32'(tx_data), 32'hA5);
    chk("s1_count_popped", 32'(count), 32'd0);
    step(1);
    chk("s1_start_one_cycle", 32'(tx_start), 32'd0);
    wait_idle(400, "s1_wait_idle");
    step(20);
    chk("s1_single_start", 32'(n_starts - base), 32'd1);

    // 2: fill and overflow while the transmitter reports busy
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      do_push(8'(i));
      if (i == 15) begin
        chk("s2_full", 32'(full), 32'd1);
        chk("s2_count16", 32'(count), 32'd16);
        chk("s2_no_ovf_yet", 32'(overflow), 32'd0);
      end
      if (i == 16) begin
        chk("s2_overflow", 32'(overflow), 32'd1);
        chk("s2_count_kept", 32'(count), 32'd16);
      end
    end
    step(1);
    chk("s2_overflow_pulse", 32'(overflow), 32'd0);
    chk("s2_still_full", 32'(full), 32'd1);

    // 3: drain in order with 2-cycle done-to-start spacing
    sbase     = sent_q.size();
    done_seen = 0;
    gap_en    = 1;
    hold_busy = 1'b0;
    wait_idle(16 * (FRAME + 10) + 100, "s3_wait_idle");
    gap_en    = 0;
    chk("s3_sent_count", 32'(sent_q.size() - sbase), 32'd16);
    for (int i = 0; i < 16; i++)
      if (sbase + i < sent_q.size()) chk("s3_order", 32'(sent_q[sbase + i]), 32'(i));
    chk("s3_empty", 32'(empty), 32'd1);

    // 4: push concurrent with the launch pop
    hold_busy = 1'b1;
    do_push(8'h11);
    do_push(8'h22);
    do_push(8'h33);
    chk("s4_count3", 32'(count), 32'd3);
    sbase     = sent_q.size();
    hold_busy = 1'b0;
    push      = 1'b1;
    push_data = 8'h44;
    @(posedge clk);
    #1;
    push      = 1'b0;
    chk("s4_count_same", 32'(count), 32'd3);
    chk("s4_tx_start", 32'(tx_start), 32'd1);
    chk("s4_tx_data", 32'(tx_data), 32'h11);
    wait_idle(4 * (FRAME + 10) + 100, "s4_wait_idle");
    chk("s4_sent_count", 32'(sent_q.size() - sbase), 32'd4);
    if (sent_q.size() >= 1) chk("s4_last_byte", 32'(sent_q[sent_q.size() - 1]), 32'h44);

    // 5: paced stream across pointer wrap
    sbase = sent_q.size();
    base  = n_ovf;
    for (int i = 0; i < 40; i++) begin
      do_push(8'h30 + 8'(i));
      step(119);
    end
    wait_idle(16 * (FRAME + 10) + 100, "s5_wait_idle");
    chk("s5_sent_count", 32'(sent_q.size() - sbase), 32'd40);
    for (int i = 0; i < 40; i++)
      if (sbase + i < sent_q.size()) chk("s5_order", 32'(sent_q[sbase + i]), 32'h30 + 32'(i));
    chk("s5_no_overflow", 32'(n_ovf - base), 32'd0);

    // 6: reset while a frame is in flight
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) do_push(8'h60 + 8'(i));
    hold_busy = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1);
      if (tx_start) got = 1;
    end
    chk("s6_launch_seen", 32'(got), 32'd1);
    step(20);
    chk("s6_pre_rst_data", 32'(tx_data), 32'h60);
    rst = 1'b0;
    #1;
    chk("s6_rst_tx_start", 32'(tx_start), 32'd0);
    chk("s6_rst_tx_data", 32'(tx_data), 32'h00);
    chk("s6_rst_empty", 32'(empty), 32'd1);
    chk("s6_rst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    base = n_starts;
    step(300);
    chk("s6_no_start_after_rst", 32'(n_starts - base), 32'd0);
    do_push(8'h99);
    wait_idle(400, "s6_wait_idle");
    chk("s6_new_start", 32'(n_starts - base), 32'd1);
    if (sent_q.size() >= 1) chk("s6_new_byte", 32'(sent_q[sent_q.size() - 1]), 32'h99);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
